id_ex_reg: RTL and testbench

Decode-to-execute pipeline register for the pipelined LEGv8 datapath. It sits directly downstream of the register file. Each cycle it captures the two read operands, with write-back bypass applied, together with the PC, the sign-extended immediate, the destination register and the control word, and presents them to the execute stage one cycle later. It supports stall (hold) and flush (bubble insertion) from the hazard unit, and keeps a saturating count of inserted bubbles.

---
 rtl/legv8_pkg.sv | 26 ++
 rtl/signext.sv | 28 ++
 rtl/id_ex_reg.sv | 143 ++++++++++++++
 tb/tb_id_ex_reg.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the pipelined LEGv8 datapath.
//   ctrl_t  : packed control word carried down the pipeline
//   OP_*    : opcode field values used by the immediate decoder
//   XZR     : zero register index, never a bypass target
package legv8_pkg;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;  // instr[31:21]
    localparam logic [10:0] OP_STUR = 11'b11111000000;  // instr[31:21]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;      // instr[31:24]
    localparam logic [5:0]  OP_B    = 6'b000101;        // instr[31:26]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;   // instr[31:22]

    localparam logic [4:0]  XZR = 5'd31;

endpackage

// File: rtl/signext.sv
// Combinational immediate decoder.
//   instr : 32-bit instruction word
//   imm   : N-bit immediate, unshifted (branch <<2 happens downstream)
// LDUR/STUR, CBZ and B immediates are sign-extended; ADDI is zero-extended;
// any other opcode yields 0.
module signext
    import legv8_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm
);

    always_comb begin
        imm = '0;
        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            imm = {{(N-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:24] == OP_CBZ) begin
            imm = {{(N-19){instr[23]}}, instr[23:5]};
        end else if (instr[31:26] == OP_B) begin
            imm = {{(N-26){instr[25]}}, instr[25:0]};
        end else if (instr[31:22] == OP_ADDI) begin
            imm = {{(N-12){1'b0}}, instr[21:10]};
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register.
// Captures operands (with write-back bypass), PC, immediate, addresses and
// control word; supports stall (hold) and flush (bubble), and counts bubbles
// with a saturating counter.
//   clk, reset_n          : clock, synchronous active-low reset
//   stall, flush          : hazard-unit controls (flush wins)
//   valid_i..rd2_i        : decode-stage inputs
//   wb_we_i/wa_i/wd_i     : write-back port, used for same-cycle bypass
//   valid_o..ctrl_o       : registered execute-stage outputs
//   bubbles_o             : saturating flush count
module id_ex_reg
    import legv8_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_i,
    input  logic [N-1:0]  pc_i,
    input  logic [31:0]   instr_i,
    input  ctrl_t         ctrl_i,
    input  logic [4:0]    ra1_i,
    input  logic [4:0]    ra2_i,
    input  logic [N-1:0]  rd1_i,
    input  logic [N-1:0]  rd2_i,
    input  logic          wb_we_i,
    input  logic [4:0]    wb_wa_i,
    input  logic [N-1:0]  wb_wd_i,
    output logic          valid_o,
    output logic [N-1:0]  pc_o,
    output logic [N-1:0]  rd1_o,
    output logic [N-1:0]  rd2_o,
    output logic [N-1:0]  imm_o,
    output logic [4:0]    ra1_o,
    output logic [4:0]    ra2_o,
    output logic [4:0]    wa_o,
    output ctrl_t         ctrl_o,
    output logic [CW-1:0] bubbles_o
);

    logic          valid_q, valid_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  rd1_q, rd1_d;
    logic [N-1:0]  rd2_q, rd2_d;
    logic [N-1:0]  imm_q, imm_d;
    logic [4:0]    ra1_q, ra1_d;
    logic [4:0]    ra2_q, ra2_d;
    logic [4:0]    wa_q, wa_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [CW-1:0] bubbles_q, bubbles_d;

    logic [N-1:0]  imm_dec;
    logic          byp1, byp2;

    signext #(
        .N (N)
    ) u_signext (
        .instr (instr_i),
        .imm   (imm_dec)
    );

    // The register file writes on the same edge we capture, so its read data
    // is stale when the write-back targets one of our sources.
    assign byp1 = wb_we_i && (wb_wa_i == ra1_i) && (ra1_i != XZR);
    assign byp2 = wb_we_i && (wb_wa_i == ra2_i) && (ra2_i != XZR);

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        ra1_d     = ra1_q;
        ra2_d     = ra2_q;
        wa_d      = wa_q;
        ctrl_d    = ctrl_q;
        bubbles_d = bubbles_q;

        if (flush) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            ra1_d     = '0;
            ra2_d     = '0;
            wa_d      = '0;
            ctrl_d    = '0;
            bubbles_d = (&bubbles_q) ? bubbles_q : bubbles_q + 1'b1;
        end else if (!stall) begin
            valid_d = valid_i;
            pc_d    = pc_i;
            rd1_d   = byp1 ? wb_wd_i : rd1_i;
            rd2_d   = byp2 ? wb_wd_i : rd2_i;
            imm_d   = imm_dec;
            ra1_d   = ra1_i;
            ra2_d   = ra2_i;
            wa_d    = instr_i[4:0];
            ctrl_d  = valid_i ? ctrl_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            wa_q      <= '0;
            ctrl_q    <= '0;
            bubbles_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            wa_q      <= wa_d;
            ctrl_q    <= ctrl_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign rd1_o     = rd1_q;
    assign rd2_o     = rd2_q;
    assign imm_o     = imm_q;
    assign ra1_o     = ra1_q;
    assign ra2_o     = ra2_q;
    assign wa_o      = wa_q;
    assign ctrl_o    = ctrl_q;
    assign bubbles_o = bubbles_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus a randomized run,
// all compared against a behavioural model of the stage.
module tb_id_ex_reg;
    import legv8_pkg::*;

    localparam int unsigned N  = 64;
    localparam int unsigned CW = 2;
    localparam int unsigned SW = 1 + 4*N + 15 + $bits(ctrl_t) + CW;
    localparam int BUB_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n, stall, flush, valid_i, wb_we_i;
    logic [N-1:0]  pc_i, rd1_i, rd2_i, wb_wd_i;
    logic [31:0]   instr_i;
    ctrl_t         ctrl_i;
    logic [4:0]    ra1_i, ra2_i, wb_wa_i;
    logic          valid_o;
    logic [N-1:0]  pc_o, rd1_o, rd2_o, imm_o;
    logic [4:0]    ra1_o, ra2_o, wa_o;
    ctrl_t         ctrl_o;
    logic [CW-1:0] bubbles_o;

    int checks = 0;
    int failures = 0;

    // Model state
    logic          m_valid;
    logic [N-1:0]  m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]    m_ra1, m_ra2, m_wa;
    ctrl_t         m_ctrl;
    int            m_bub;

    logic [SW-1:0] dut_state, exp_state;

    assign dut_state = {valid_o, pc_o, rd1_o, rd2_o, imm_o, ra1_o, ra2_o, wa_o, ctrl_o,
                        bubbles_o};
    assign exp_state = {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_ra1, m_ra2, m_wa, m_ctrl,
                        CW'(m_bub)};

    always #5 clk = ~clk;

    id_ex_reg #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .valid_i   (valid_i),
        .pc_i      (pc_i),
        .instr_i   (instr_i),
        .ctrl_i    (ctrl_i),
        .ra1_i     (ra1_i),
        .ra2_i     (ra2_i),
        .rd1_i     (rd1_i),
        .rd2_i     (rd2_i),
        .wb_we_i   (wb_we_i),
        .wb_wa_i   (wb_wa_i),
        .wb_wd_i   (wb_wd_i),
        .valid_o   (valid_o),
        .pc_o      (pc_o),
        .rd1_o     (rd1_o),
        .rd2_o     (rd2_o),
        .imm_o     (imm_o),
        .ra1_o     (ra1_o),
        .ra2_o     (ra2_o),
        .wa_o      (wa_o),
        .ctrl_o    (ctrl_o),
        .bubbles_o (bubbles_o)
    );

    // Immediate as a signed integer value of the selected field.
    function automatic logic [N-1:0] ref_imm(input logic [31:0] ins);
        longint v;
        logic [31:0] f;
        v = 0;
        if (ins[31:21] == OP_LDUR || ins[31:21] == OP_STUR) begin
            f = (ins >> 12) & 32'h1FF;
            v = longint'(f);
            if (v >= 256) v = v - 512;
        end else if (ins[31:24] == OP_CBZ) begin
            f = (ins >> 5) & 32'h7FFFF;
            v = longint'(f);
            if (v >= (1 << 18)) v = v - (1 << 19);
        end else if (ins[31:26] == OP_B) begin
            f = ins & 32'h3FFFFFF;
            v = longint'(f);
            if (v >= (1 << 25)) v = v - (1 << 26);
        end else if (ins[31:22] == OP_ADDI) begin
            f = (ins >> 10) & 32'hFFF;
            v = longint'(f);
        end
        return N'(v);
    endfunction

    function automatic logic [N-1:0] ref_operand(input logic [4:0] ra, input logic [N-1:0] rd);
        if (wb_we_i && wb_wa_i == ra && ra != 5'd31) return wb_wd_i;
        return rd;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_ra1 = '0; m_ra2 = '0; m_wa = '0; m_ctrl = '0;
    endtask

    // Evaluate the model on the current inputs, then advance one clock.
    task automatic step();
        if (!reset_n) begin
            model_clear();
            m_bub = 0;
        end else if (flush) begin
            model_clear();
            if (m_bub < BUB_MAX) m_bub = m_bub + 1;
        end else if (!stall) begin
            m_valid = valid_i;
            m_pc    = pc_i;
            m_rd1   = ref_operand(ra1_i, rd1_i);
            m_rd2   = ref_operand(ra2_i, rd2_i);
            m_imm   = ref_imm(instr_i);
            m_ra1   = ra1_i;
            m_ra2   = ra2_i;
            m_wa    = instr_i[4:0];
            m_ctrl  = valid_i ? ctrl_i : '0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[31:21] = OP_LDUR;
            1: w[31:21] = OP_STUR;
            2: w[31:24] = OP_CBZ;
            3: w[31:26] = OP_B;
            4: w[31:22] = OP_ADDI;
            default: ;
        endcase
        return w;
    endfunction

    task automatic drive_random();
        valid_i = 1'($urandom);
        pc_i    = {$urandom, $urandom};
        instr_i = rand_instr();
        ctrl_i  = ctrl_t'(9'($urandom));
        ra1_i   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
        ra2_i   = 5'($urandom);
        rd1_i   = {$urandom, $urandom};
        rd2_i   = {$urandom, $urandom};
        wb_we_i = 1'($urandom);
        wb_wd_i = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: wb_wa_i = ra1_i;
            1: wb_wa_i = ra2_i;
            2: wb_wa_i = 5'd31;
            default: wb_wa_i = 5'($urandom);
        endcase
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_random();
        valid_i = 1'b1;
        step();
        step();
        checks++;
        if (dut_state !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", dut_state);
        end
        checks++;
        if (dut_state !== exp_state) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", dut_state, exp_state);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_addi_load();
        drive_random();
        valid_i = 1'b1; wb_we_i = 1'b0;
        pc_i = 64'h40; ra1_i = 5'd1; rd1_i = 64'd5;
        instr_i = {OP_ADDI, 12'd7, 5'd1, 5'd2};
        step();
        checks++;
        if (pc_o !== 64'h40 || rd1_o !== 64'd5 || imm_o !== 64'd7 || wa_o !== 5'd2 ||
            valid_o !== 1'b1) begin
            failures++;
            $display("FAIL addi_load got pc=%h rd1=%h imm=%h wa=%0d v=%b exp pc=40 rd1=5 imm=7 wa=2 v=1",
                     pc_o, rd1_o, imm_o, wa_o, valid_o);
        end
        checks++;
        if (dut_state !== exp_state) begin
            failures++;
            $display("FAIL addi_model got=%h exp=%h", dut_state, exp_state);
        end
    endtask

    task automatic test_bypass();
        drive_random();
        ra1_i = 5'd3; rd1_i = '0; ra2_i = 5'd9;
        wb_we_i = 1'b1; wb_wa_i = 5'd3; wb_wd_i = 64'hDEAD;
        step();
        checks++;
        if (rd1_o !== 64'hDEAD) begin
            failures++;
            $display("FAIL bypass_rd1 got=%h exp=dead", rd1_o);
        end
        ra1_i = 5'd31; wb_wa_i = 5'd31; rd1_i = 64'h1234;
        step();
        checks++;
        if (rd1_o !== 64'h1234) begin
            failures++;
            $display("FAIL bypass_xzr got=%h exp=1234", rd1_o);
        end
        ra1_i = 5'd4; ra2_i = 5'd7; wb_wa_i = 5'd7; rd1_i = 64'h11; rd2_i = 64'h22;
        wb_wd_i = 64'hBEEF;
        step();
        checks++;
        if (rd2_o !== 64'hBEEF || rd1_o !== 64'h11) begin
            failures++;
            $display("FAIL bypass_rd2 got rd1=%h rd2=%h exp rd1=11 rd2=beef", rd1_o, rd2_o);
        end
        wb_we_i = 1'b0;
        step();
        checks++;
        if (rd2_o !== 64'h22) begin
            failures++;
            $display("FAIL bypass_we_off got=%h exp=22", rd2_o);
        end
    endtask

    task automatic test_immediates();
        drive_random();
        instr_i = {OP_LDUR, 9'h1FF, 2'b00, 5'd1, 5'd3};
        step();
        checks++;
        if (imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL imm_ldur got=%h exp=ffffffffffffffff", imm_o);
        end
        instr_i = {OP_CBZ, 19'h00010, 5'd4};
        step();
        checks++;
        if (imm_o !== 64'h10) begin
            failures++;
            $display("FAIL imm_cbz got=%h exp=10", imm_o);
        end
        instr_i = {OP_B, 26'h3FFFFFF};
        step();
        checks++;
        if (imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL imm_b got=%h exp=ffffffffffffffff", imm_o);
        end
        instr_i = {OP_STUR, 9'h0FF, 2'b00, 5'd1, 5'd3};
        step();
        checks++;
        if (imm_o !== 64'hFF) begin
            failures++;
            $display("FAIL imm_stur got=%h exp=ff", imm_o);
        end
        instr_i = 32'hD503_201F;
        step();
        checks++;
        if (imm_o !== 64'h0) begin
            failures++;
            $display("FAIL imm_other got=%h exp=0", imm_o);
        end
    endtask

    task automatic test_stall();
        logic [SW-1:0] held;
        drive_random();
        valid_i = 1'b1;
        step();
        held = exp_state;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
            checks++;
            if (dut_state !== held) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, dut_state, held);
            end
        end
        stall = 1'b0;
        drive_random();
        valid_i = 1'b1;
        step();
        checks++;
        if (dut_state !== exp_state) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", dut_state, exp_state);
        end
    endtask

    task automatic test_flush_stall();
        drive_random();
        stall = 1'b1; flush = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0 || ctrl_o !== '0 || bubbles_o !== CW'(1)) begin
            failures++;
            $display("FAIL flush_stall got v=%b ctrl=%h bub=%0d exp v=0 ctrl=0 bub=1",
                     valid_o, ctrl_o, bubbles_o);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_random();
            step();
        end
        checks++;
        if (bubbles_o !== CW'(BUB_MAX) || dut_state !== exp_state) begin
            failures++;
            $display("FAIL flush_saturate got bub=%0d state=%h exp bub=%0d state=%h",
                     bubbles_o, dut_state, BUB_MAX, exp_state);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_in_stall();
        drive_random();
        valid_i = 1'b1;
        step();
        stall = 1'b1;
        reset_n = 1'b0;
        drive_random();
        step();
        checks++;
        if (dut_state !== '0) begin
            failures++;
            $display("FAIL reset_in_stall got=%h exp=0", dut_state);
        end
        reset_n = 1'b1;
        stall = 1'b0;
        drive_random();
        valid_i = 1'b1;
        step();
        checks++;
        if (dut_state !== exp_state) begin
            failures++;
            $display("FAIL first_load got=%h exp=%h", dut_state, exp_state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            reset_n = ($urandom_range(0, 49) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 5) == 0);
            step();
            checks++;
            if (dut_state !== exp_state) begin
                failures++;
                $display("FAIL random[%0d] got=%h exp=%h", i, dut_state, exp_state);
            end
        end
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        m_bub = 0;
        model_clear();
        test_reset();
        test_addi_load();
        test_bypass();
        test_immediates();
        test_stall();
        test_flush_stall();
        test_reset_in_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
